pipeline_hazard_controller: RTL



---
 rtl/pipeline_hazard_controller_if.sv | 41 ++++
 rtl/pipeline_hazard_controller.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_controller_if.sv
// Control bundle between the pipeline datapath and the hazard sequencer.
// slave: hazard controller side; master: pipeline side that reports hazards and consumes enables.
interface pipeline_hazard_controller_if;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_uses_rs1;
  logic        id_uses_rs2;
  logic [4:0]  ex_rd;
  logic        ex_mem_read;
  logic        ex_branch_taken;
  logic        ex_force_jump;
  logic        mem_req;
  logic        mem_ready;
  logic        pc_write_en;
  logic        if_id_write_en;
  logic        id_ex_write_en;
  logic        ex_mem_write_en;
  logic        pc_redirect;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        mem_wb_flush;
  logic        mem_timeout;
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_flush_events;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, ex_force_jump, mem_req, mem_ready,
    input  pc_write_en, if_id_write_en, id_ex_write_en, ex_mem_write_en,
           pc_redirect, if_id_flush, id_ex_flush, mem_wb_flush, mem_timeout,
           perf_stall_cycles, perf_flush_events
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, ex_force_jump, mem_req, mem_ready,
    output pc_write_en, if_id_write_en, id_ex_write_en, ex_mem_write_en,
           pc_redirect, if_id_flush, id_ex_flush, mem_wb_flush, mem_timeout,
           perf_stall_cycles, perf_flush_events
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Hazard sequencer for the 5-stage core: load-use stalls, EX redirects and data-memory waits.
// Optional performance counters are built when HAZARD_PERF_COUNTERS_EN is defined.
module pipeline_hazard_controller #(
  parameter int LOAD_USE_BUBBLES = 1,
  parameter int MEM_TIMEOUT      = 255
) (
  input logic                          CLK,
  input logic                          RESET,
  pipeline_hazard_controller_if.slave  hz
);

  typedef enum logic [1:0] {RUN, STALL, MEM_WAIT} state_t;

  localparam int               WAIT_W      = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX   = WAIT_W'(MEM_TIMEOUT);
  localparam logic [1:0]       BUBBLE_INIT = 2'(LOAD_USE_BUBBLES - 1);

  state_t            state, state_nxt;
  logic [1:0]        bubble_cnt, bubble_cnt_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic              timeout_q, timeout_nxt;

  logic mem_wait, redirect, load_use, stall_active;
  logic pc_we, if_id_we, id_ex_we, ex_mem_we;
  logic redir, if_id_fl, id_ex_fl, mem_wb_fl;

  function automatic logic [WAIT_W-1:0] sat_inc_wait(input logic [WAIT_W-1:0] v);
    return (v >= WAIT_MAX) ? WAIT_MAX : v + WAIT_W'(1);
  endfunction

  assign mem_wait = hz.mem_req && !hz.mem_ready;
  assign redirect = hz.ex_branch_taken || hz.ex_force_jump;
  assign load_use = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
                    ((hz.id_uses_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                     (hz.id_uses_rs2 && (hz.id_rs2 == hz.ex_rd)));
  // A memory wait entered from STALL keeps its frozen countdown and resumes it afterwards.
  assign stall_active = (state == STALL) || ((state == MEM_WAIT) && (bubble_cnt != 2'd0));

  always_comb begin
    pc_we          = 1'b1;
    if_id_we       = 1'b1;
    id_ex_we       = 1'b1;
    ex_mem_we      = 1'b1;
    redir          = 1'b0;
    if_id_fl       = 1'b0;
    id_ex_fl       = 1'b0;
    mem_wb_fl      = 1'b0;
    state_nxt      = state;
    bubble_cnt_nxt = bubble_cnt;
    wait_cnt_nxt   = '0;
    timeout_nxt    = timeout_q;

    if (RESET) begin
      state_nxt      = RUN;
      bubble_cnt_nxt = 2'd0;
      timeout_nxt    = 1'b0;
    end else if (mem_wait) begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      id_ex_we     = 1'b0;
      ex_mem_we    = 1'b0;
      mem_wb_fl    = 1'b1;
      state_nxt    = MEM_WAIT;
      wait_cnt_nxt = sat_inc_wait(wait_cnt);
      if ((MEM_TIMEOUT != 0) && (wait_cnt_nxt == WAIT_MAX))
        timeout_nxt = 1'b1;
    end else if (redirect) begin
      redir          = 1'b1;
      if_id_fl       = 1'b1;
      id_ex_fl       = 1'b1;
      state_nxt      = RUN;
      bubble_cnt_nxt = 2'd0;
    end else if (stall_active) begin
      pc_we    = 1'b0;
      if_id_we = 1'b0;
      id_ex_fl = 1'b1;
      if (bubble_cnt <= 2'd1) begin
        state_nxt      = RUN;
        bubble_cnt_nxt = 2'd0;
      end else begin
        state_nxt      = STALL;
        bubble_cnt_nxt = bubble_cnt - 2'd1;
      end
    end else if (load_use) begin
      pc_we    = 1'b0;
      if_id_we = 1'b0;
      id_ex_fl = 1'b1;
      if (LOAD_USE_BUBBLES > 1) begin
        state_nxt      = STALL;
        bubble_cnt_nxt = BUBBLE_INIT;
      end else begin
        state_nxt = RUN;
      end
    end else begin
      state_nxt = RUN;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= RUN;
      bubble_cnt <= 2'd0;
      wait_cnt   <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state      <= state_nxt;
      bubble_cnt <= bubble_cnt_nxt;
      wait_cnt   <= wait_cnt_nxt;
      timeout_q  <= timeout_nxt;
    end
  end

  assign hz.pc_write_en     = pc_we;
  assign hz.if_id_write_en  = if_id_we;
  assign hz.id_ex_write_en  = id_ex_we;
  assign hz.ex_mem_write_en = ex_mem_we;
  assign hz.pc_redirect     = redir;
  assign hz.if_id_flush     = if_id_fl;
  assign hz.id_ex_flush     = id_ex_fl;
  assign hz.mem_wb_flush    = mem_wb_fl;
  assign hz.mem_timeout     = timeout_q;

`ifdef HAZARD_PERF_COUNTERS_EN
  logic [31:0] stall_cycles_q, flush_events_q;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge CLK) begin
    if (RESET) begin
      stall_cycles_q <= 32'd0;
      flush_events_q <= 32'd0;
    end else begin
      if (!pc_we) stall_cycles_q <= sat_inc32(stall_cycles_q);
      if (redir)  flush_events_q <= sat_inc32(flush_events_q);
    end
  end

  assign hz.perf_stall_cycles = stall_cycles_q;
  assign hz.perf_flush_events = flush_events_q;
`else
  assign hz.perf_stall_cycles = 32'd0;
  assign hz.perf_flush_events = 32'd0;
`endif

endmodule
